lag_measure_sequencer: RTL and testbench

Sequences one latency measurement per test-pattern flash. It arms on the video start trigger, counts fixed-period ticks until the light sensor's rising edge, and times out on missed flashes. It accumulates min/max/average over a window of samples for on-screen display. It sits in the `clock` (27 MHz) domain, between the start-trigger flag crossing and the BCD conversion/display path.

---
 rtl/lag_measure_sequencer_pkg.sv | 22 ++
 rtl/lag_stats_accumulator.sv | 98 +++++++++
 rtl/lag_measure_sequencer.sv | 152 +++++++++++++++
 tb/tb_lag_measure_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lag_measure_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// lag_measure_sequencer_pkg
// Shared definitions for the latency-measurement sequencer: the sequencer
// state encoding and the default timing constants for a 27 MHz clock.
// -----------------------------------------------------------------------------
package lag_measure_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_MEASURE = 2'd2
  } seq_state_t;

  // 27 clock cycles per tick = 1 us at 27 MHz.
  localparam int DEFAULT_TICK_DIVIDER  = 27;
  localparam int DEFAULT_COUNT_WIDTH   = 20;
  // Half a second of ticks; must stay below 2**COUNT_WIDTH.
  localparam int DEFAULT_TIMEOUT_TICKS = 500000;
  // 16 samples per statistics window.
  localparam int DEFAULT_SAMPLE_SHIFT  = 4;

endpackage

// File: rtl/lag_stats_accumulator.sv
// -----------------------------------------------------------------------------
// lag_stats_accumulator
// Collects min / max / sum over a window of 2**SAMPLE_SHIFT samples and
// publishes min, max and the truncated average when the window fills.
// Published values hold until the next window completes or clear is pulsed.
//
// Ports:
//   clock, reset   system clock, asynchronous active-high reset
//   sample         tick count to accumulate
//   valid          one-cycle strobe, sample is new this cycle
//   clear          one-cycle strobe, drops the window and published values;
//                  a sample arriving with it is discarded
//   min_lag        published window minimum
//   max_lag        published window maximum
//   avg_lag        published window average (sum >> SAMPLE_SHIFT)
//   stats_valid    high once a full window has been published
// -----------------------------------------------------------------------------
module lag_stats_accumulator #(
  parameter int COUNT_WIDTH  = 20,
  parameter int SAMPLE_SHIFT = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [COUNT_WIDTH-1:0] sample,
  input  logic                   valid,
  input  logic                   clear,
  output logic [COUNT_WIDTH-1:0] min_lag,
  output logic [COUNT_WIDTH-1:0] max_lag,
  output logic [COUNT_WIDTH-1:0] avg_lag,
  output logic                   stats_valid
);

  localparam int SUM_WIDTH = COUNT_WIDTH + SAMPLE_SHIFT;
  localparam int CNT_WIDTH = SAMPLE_SHIFT + 1;
  localparam logic [CNT_WIDTH-1:0] WINDOW = CNT_WIDTH'(1) << SAMPLE_SHIFT;

  logic [SUM_WIDTH-1:0]   sum_q;
  logic [CNT_WIDTH-1:0]   count_q;
  logic [COUNT_WIDTH-1:0] min_q;
  logic [COUNT_WIDTH-1:0] max_q;

  logic [SUM_WIDTH-1:0]   sum_next;
  logic [CNT_WIDTH-1:0]   count_next;
  logic [COUNT_WIDTH-1:0] min_next;
  logic [COUNT_WIDTH-1:0] max_next;

  // The window including the current sample; used both to store and to
  // publish, so the last sample of a window is part of its statistics.
  // NOTE: every always_comb output is assigned on every path so no latch
  // is inferred.
  always_comb begin
    sum_next   = sum_q + SUM_WIDTH'(sample);
    count_next = count_q + CNT_WIDTH'(1);
    min_next   = (sample < min_q) ? sample : min_q;
    max_next   = (sample > max_q) ? sample : max_q;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q       <= '0;
      count_q     <= '0;
      min_q       <= '1;
      max_q       <= '0;
      min_lag     <= '0;
      max_lag     <= '0;
      avg_lag     <= '0;
      stats_valid <= 1'b0;
    end else if (clear) begin
      sum_q       <= '0;
      count_q     <= '0;
      min_q       <= '1;
      max_q       <= '0;
      min_lag     <= '0;
      max_lag     <= '0;
      avg_lag     <= '0;
      stats_valid <= 1'b0;
    end else if (valid) begin
      if (count_next == WINDOW) begin
        min_lag     <= min_next;
        max_lag     <= max_next;
        avg_lag     <= COUNT_WIDTH'(sum_next >> SAMPLE_SHIFT);
        stats_valid <= 1'b1;
        sum_q       <= '0;
        count_q     <= '0;
        min_q       <= '1;
        max_q       <= '0;
      end else begin
        sum_q   <= sum_next;
        count_q <= count_next;
        min_q   <= min_next;
        max_q   <= max_next;
      end
    end
  end

endmodule

// File: rtl/lag_measure_sequencer.sv
// -----------------------------------------------------------------------------
// lag_measure_sequencer
// Measures display lag once per test-pattern flash: arms on the start
// trigger, counts fixed-period ticks until the sensor's rising edge, and
// gives up after TIMEOUT_TICKS. Valid samples feed a windowed min/max/avg.
//
// Ports:
//   clock, reset    27 MHz clock, asynchronous active-high reset
//   enable          level; low returns to IDLE and aborts silently
//   starttrigger    one-cycle flash-onset pulse (accepted only when ARMED)
//   sensor          synchronized light level, high = light
//   clear_stats     one-cycle pulse, clears the statistics window
//   counter_reset   one-cycle pulse on an accepted trigger
//   sample_valid    one-cycle pulse, sample_value was just updated
//   sample_value    last measured tick count (held)
//   sample_timeout  one-cycle pulse, measurement abandoned
//   min_lag, max_lag, avg_lag, stats_valid   published window statistics
//   busy            high while measuring
// -----------------------------------------------------------------------------
module lag_measure_sequencer
  import lag_measure_sequencer_pkg::*;
#(
  parameter int TICK_DIVIDER  = DEFAULT_TICK_DIVIDER,
  parameter int COUNT_WIDTH   = DEFAULT_COUNT_WIDTH,
  parameter int TIMEOUT_TICKS = DEFAULT_TIMEOUT_TICKS,
  parameter int SAMPLE_SHIFT  = DEFAULT_SAMPLE_SHIFT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   starttrigger,
  input  logic                   sensor,
  input  logic                   clear_stats,
  output logic                   counter_reset,
  output logic                   sample_valid,
  output logic [COUNT_WIDTH-1:0] sample_value,
  output logic                   sample_timeout,
  output logic [COUNT_WIDTH-1:0] min_lag,
  output logic [COUNT_WIDTH-1:0] max_lag,
  output logic [COUNT_WIDTH-1:0] avg_lag,
  output logic                   stats_valid,
  output logic                   busy
);

  localparam int DIV_WIDTH = (TICK_DIVIDER > 1) ? $clog2(TICK_DIVIDER) : 1;
  localparam logic [DIV_WIDTH-1:0]   DIV_LAST     = DIV_WIDTH'(TICK_DIVIDER - 1);
  localparam logic [COUNT_WIDTH-1:0] TIMEOUT_LAST = COUNT_WIDTH'(TIMEOUT_TICKS - 1);

  seq_state_t             state;
  logic [DIV_WIDTH-1:0]   divider;
  logic [COUNT_WIDTH-1:0] ticks;
  logic                   sensor_prev;

  logic sensor_rise;
  logic tick_wrap;
  logic capture;
  logic timed_out;

  // capture sees ticks before this edge's increment, so a rise at edge Em
  // records floor((m-1)/TICK_DIVIDER). The timeout fires on the edge that
  // would take ticks to TIMEOUT_TICKS; a coincident rise takes priority.
  always_comb begin
    sensor_rise = sensor & ~sensor_prev;
    tick_wrap   = (divider == DIV_LAST);
    capture     = enable && (state == ST_MEASURE) && sensor_rise;
    timed_out   = enable && (state == ST_MEASURE) && tick_wrap &&
                  (ticks == TIMEOUT_LAST);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      divider        <= '0;
      ticks          <= '0;
      sensor_prev    <= 1'b0;
      counter_reset  <= 1'b0;
      sample_valid   <= 1'b0;
      sample_value   <= '0;
      sample_timeout <= 1'b0;
      busy           <= 1'b0;
    end else begin
      // Tracked in every state so a sensor already high at the trigger is
      // never mistaken for an edge.
      sensor_prev    <= sensor;
      counter_reset  <= 1'b0;
      sample_valid   <= 1'b0;
      sample_timeout <= 1'b0;

      if (!enable) begin
        state <= ST_IDLE;
        busy  <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            state <= ST_ARMED;
          end

          ST_ARMED: begin
            if (starttrigger) begin
              state         <= ST_MEASURE;
              busy          <= 1'b1;
              counter_reset <= 1'b1;
              divider       <= '0;
              ticks         <= '0;
            end
          end

          ST_MEASURE: begin
            if (tick_wrap) begin
              divider <= '0;
              ticks   <= ticks + COUNT_WIDTH'(1);
            end else begin
              divider <= divider + DIV_WIDTH'(1);
            end

            if (capture) begin
              sample_valid <= 1'b1;
              sample_value <= ticks;
              state        <= ST_ARMED;
              busy         <= 1'b0;
            end else if (timed_out) begin
              sample_timeout <= 1'b1;
              state          <= ST_ARMED;
              busy           <= 1'b0;
            end
          end

          default: begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  lag_stats_accumulator #(
    .COUNT_WIDTH (COUNT_WIDTH),
    .SAMPLE_SHIFT(SAMPLE_SHIFT)
  ) u_stats (
    .clock      (clock),
    .reset      (reset),
    .sample     (ticks),
    .valid      (capture),
    .clear      (clear_stats),
    .min_lag    (min_lag),
    .max_lag    (max_lag),
    .avg_lag    (avg_lag),
    .stats_valid(stats_valid)
  );

endmodule

// File: tb/tb_lag_measure_sequencer.sv
// -----------------------------------------------------------------------------
// tb_lag_measure_sequencer
// Directed-plus-random bench for lag_measure_sequencer. Expected samples
// come from the tick rule floor((m-1)/TICK_DIVIDER); expected statistics
// come from a queue of the samples in the current window.
// -----------------------------------------------------------------------------
module tb_lag_measure_sequencer;

  localparam int TD     = 27;
  localparam int CW     = 20;
  localparam int TO     = 100;
  localparam int SS     = 4;
  localparam int WINDOW = 1 << SS;

  logic          clock;
  logic          reset;
  logic          enable;
  logic          starttrigger;
  logic          sensor;
  logic          clear_stats;
  logic          counter_reset;
  logic          sample_valid;
  logic [CW-1:0] sample_value;
  logic          sample_timeout;
  logic [CW-1:0] min_lag;
  logic [CW-1:0] max_lag;
  logic [CW-1:0] avg_lag;
  logic          stats_valid;
  logic          busy;

  int total = 0;
  int bad   = 0;

  // Reference model state
  int unsigned win_q[$];
  int unsigned exp_min = 0;
  int unsigned exp_max = 0;
  int unsigned exp_avg = 0;
  bit          exp_sv  = 1'b0;
  int unsigned last_value = 0;

  lag_measure_sequencer #(
    .TICK_DIVIDER (TD),
    .COUNT_WIDTH  (CW),
    .TIMEOUT_TICKS(TO),
    .SAMPLE_SHIFT (SS)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .enable        (enable),
    .starttrigger  (starttrigger),
    .sensor        (sensor),
    .clear_stats   (clear_stats),
    .counter_reset (counter_reset),
    .sample_valid  (sample_valid),
    .sample_value  (sample_value),
    .sample_timeout(sample_timeout),
    .min_lag       (min_lag),
    .max_lag       (max_lag),
    .avg_lag       (avg_lag),
    .stats_valid   (stats_valid),
    .busy          (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
  endtask

  task automatic checkw(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
  endtask

  function automatic void model_clear();
    win_q.delete();
    exp_min = 0;
    exp_max = 0;
    exp_avg = 0;
    exp_sv  = 1'b0;
  endfunction

  function automatic void model_sample(input int unsigned v, input bit clr);
    int unsigned mn;
    int unsigned mx;
    int unsigned sm;
    if (clr) begin
      model_clear();
      return;
    end
    win_q.push_back(v);
    if (win_q.size() == WINDOW) begin
      mn = win_q[0];
      mx = win_q[0];
      sm = 0;
      foreach (win_q[i]) begin
        if (win_q[i] < mn) mn = win_q[i];
        if (win_q[i] > mx) mx = win_q[i];
        sm += win_q[i];
      end
      exp_min = mn;
      exp_max = mx;
      exp_avg = sm / WINDOW;
      exp_sv  = 1'b1;
      win_q.delete();
    end
  endfunction

  task automatic check_stats(input string tag);
    checkw({tag, "_min"}, min_lag, CW'(exp_min));
    checkw({tag, "_max"}, max_lag, CW'(exp_max));
    checkw({tag, "_avg"}, avg_lag, CW'(exp_avg));
    check1({tag, "_sv"}, stats_valid, exp_sv);
  endtask

  task automatic check_all_zero(input string tag);
    check1({tag, "_counter_reset"}, counter_reset, 1'b0);
    check1({tag, "_sample_valid"}, sample_valid, 1'b0);
    checkw({tag, "_sample_value"}, sample_value, '0);
    check1({tag, "_sample_timeout"}, sample_timeout, 1'b0);
    checkw({tag, "_min"}, min_lag, '0);
    checkw({tag, "_max"}, max_lag, '0);
    checkw({tag, "_avg"}, avg_lag, '0);
    check1({tag, "_stats_valid"}, stats_valid, 1'b0);
    check1({tag, "_busy"}, busy, 1'b0);
  endtask

  // Random edge position whose expected tick value is small.
  function automatic int rand_m();
    int unsigned v;
    v = $urandom_range(0, 8);
    return TD * int'(v) + 1 + int'($urandom_range(0, TD - 1));
  endfunction

  // One full measurement from ARMED with sensor low: trigger at E0,
  // sensor first high at Em, optional clear_stats on the same edge.
  task automatic measure(input int m, input bit clr);
    int unsigned v;
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    check1("counter_reset", counter_reset, 1'b1);
    check1("busy_start", busy, 1'b1);
    repeat (m - 1) step();
    check1("no_early_sample", sample_valid, 1'b0);
    sensor      = 1'b1;
    clear_stats = clr;
    step();
    clear_stats = 1'b0;
    v = int'(m - 1) / TD;
    check1("sample_valid", sample_valid, 1'b1);
    checkw("sample_value", sample_value, CW'(v));
    check1("busy_end", busy, 1'b0);
    last_value = v;
    model_sample(v, clr);
    check_stats("stats");
    sensor = 1'b0;
    step();
    check1("sample_valid_pulse", sample_valid, 1'b0);
    check1("counter_reset_pulse", counter_reset, 1'b0);
  endtask

  initial begin
    reset        = 1'b1;
    enable       = 1'b0;
    starttrigger = 1'b0;
    sensor       = 1'b0;
    clear_stats  = 1'b0;
    repeat (3) step();
    check_all_zero("reset");
    reset = 1'b0;
    enable = 1'b1;
    step();                                   // IDLE -> ARMED

    // 1: sensor first high at E271 -> 10 ticks
    measure(271, 1'b0);
    checkw("t1_value", sample_value, CW'(10));

    // 2: timeout after TO ticks, i.e. edge E(TO*TD)
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    check1("t2_counter_reset", counter_reset, 1'b1);
    repeat (TO * TD - 1) step();
    check1("t2_no_early_timeout", sample_timeout, 1'b0);
    check1("t2_busy_before", busy, 1'b1);
    step();
    check1("t2_timeout", sample_timeout, 1'b1);
    check1("t2_no_sample", sample_valid, 1'b0);
    check1("t2_busy_after", busy, 1'b0);
    checkw("t2_value_held", sample_value, CW'(last_value));
    check1("t2_stats_valid", stats_valid, 1'b0);
    check_stats("t2");
    step();
    check1("t2_timeout_pulse", sample_timeout, 1'b0);

    // 4: sensor high across the trigger, then low, then rise at E135
    sensor = 1'b1;
    repeat (2) step();
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    check1("t4_counter_reset", counter_reset, 1'b1);
    step();
    check1("t4_no_capture_e1", sample_valid, 1'b0);
    check1("t4_busy", busy, 1'b1);
    repeat (99) step();
    sensor = 1'b0;
    repeat (34) step();
    sensor = 1'b1;
    step();
    check1("t4_sample_valid", sample_valid, 1'b1);
    checkw("t4_value", sample_value, CW'(4));
    last_value = (135 - 1) / TD;
    model_sample(last_value, 1'b0);
    check_stats("t4");
    sensor = 1'b0;
    step();

    // 5: abort via enable, triggers ignored in IDLE, then normal measurement
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    repeat (50) step();
    enable = 1'b0;
    sensor = 1'b1;
    step();
    check1("t5_busy", busy, 1'b0);
    check1("t5_no_sample", sample_valid, 1'b0);
    check1("t5_no_timeout", sample_timeout, 1'b0);
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    check1("t5_idle_trigger_ignored", counter_reset, 1'b0);
    check1("t5_idle_busy", busy, 1'b0);
    check1("t5_idle_no_sample", sample_valid, 1'b0);
    sensor = 1'b0;
    step();
    enable = 1'b1;
    step();
    measure(rand_m(), 1'b0);

    // 3: window of 1..16, then a 17th sample
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    model_clear();
    check_stats("t3_clear");
    for (int v = 1; v <= 16; v++) begin
      measure(TD * v + 1 + int'($urandom_range(0, TD - 1)), 1'b0);
    end
    checkw("t3_min", min_lag, CW'(1));
    checkw("t3_max", max_lag, CW'(16));
    checkw("t3_avg", avg_lag, CW'(8));
    check1("t3_stats_valid", stats_valid, 1'b1);
    measure(rand_m(), 1'b0);

    // Random window against the model
    for (int i = 0; i < WINDOW; i++) measure(rand_m(), 1'b0);

    // 6: clear_stats coincides with the 16th sample of a window
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    model_clear();
    for (int i = 0; i < WINDOW - 1; i++) measure(rand_m(), 1'b0);
    measure(rand_m(), 1'b1);
    check1("t6_stats_valid", stats_valid, 1'b0);
    for (int i = 0; i < WINDOW; i++) measure(rand_m(), 1'b0);
    check1("t6_refill_stats_valid", stats_valid, 1'b1);

    // Asynchronous reset in the middle of a measurement
    starttrigger = 1'b1;
    step();
    starttrigger = 1'b0;
    repeat (20) step();
    check1("t6_busy_before_reset", busy, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_all_zero("async_reset");
    step();
    reset = 1'b0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
